alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Issue-side controller for the 8-bit datapath ALU. It accepts one instruction per valid/ready handshake and latches the opcode and immediate. It then drives the ALU's control inputs (`reg_en`, `add`, `load`, `imm`) through a fixed multi-cycle sequence, samples the ALU `result`, and presents it on a valid/ready output port. It sits between the instruction decoder and the ALU, and is the only block that drives ALU register enables.

## Interface
- `BUS_WIDTH`, 8, width of the immediate, the ALU result and the output data.
- `CNT_WIDTH`, 16, width of the op counter (used only with `ALU_SEQ_PERF_EN`).

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `instr_valid`  in  1  instruction offered
- `instr_ready`  out  1  controller can accept an instruction
- `instr_op`  in  2  opcode: 00 LDSW, 01 MOV, 10 ADDI, 11 NOP
- `instr_imm`  in  BUS_WIDTH  immediate operand
- `alu_reg_en`  out  5  ALU register enables; [4] = E operand, [3:0] = multiply-stage a/b/c/d
- `alu_add`  out  1  ALU add select: 1 routes the immediate to E and to the coefficient
- `alu_load`  out  1  ALU load select: 0 = switches, 1 = `data_a`
- `alu_imm`  out  BUS_WIDTH  immediate driven to the ALU
- `alu_result`  in  BUS_WIDTH  ALU result (combinational from ALU registers)
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer accepts the result
- `res_data`  out  BUS_WIDTH  captured result
- `op_count`  out  CNT_WIDTH  completed-op counter (present only with `ALU_SEQ_PERF_EN`)

## Operation
- States: IDLE, ISSUE, MULT, CAPT, HOLD.
- **IDLE**
  - `instr_ready`=1.
  - On `instr_valid`, latch `instr_op` and `instr_imm`.
  - Next state is ISSUE, or stays IDLE for NOP. NOP is consumed with no ALU activity and no result.
- **ISSUE** (1 cycle)
  - `alu_reg_en`=5'b1_0011.
  - `alu_add`/`alu_load` are set per opcode:
    - LDSW: add=0, load=0.
    - MOV: add=0, load=1.
    - ADDI: add=1, load=0.
- **MULT** (1 cycle)
  - `alu_reg_en`=5'b0_1100.
  - `alu_add`/`alu_load` hold their ISSUE values.
- **CAPT** (1 cycle)
  - `alu_reg_en`=0.
  - `res_data` <= `alu_result`. Next state is HOLD.
- **HOLD**
  - `res_valid`=1.
  - On `res_ready`, go to IDLE.
  - `res_data` is stable while `res_valid`=1 and `res_ready`=0.
- `alu_imm` holds the latched immediate from acceptance until the next acceptance. It does not change while the ALU is busy.
- `alu_add`/`alu_load` are 0 in IDLE and HOLD.
- `alu_reg_en` is 0 in every state except ISSUE and MULT.
- No arithmetic in this block. `res_data` is a bit-exact copy of `alu_result` as sampled in CAPT; ALU wrap-around passes through unchanged.
- Unknown opcodes cannot occur: the opcode is 2 bits and all four values are defined.

## Timing
- Reset (asynchronous, `rst_n`=0):
  - State = IDLE.
  - `instr_ready`=1 once `rst_n` is released; 0 while `rst_n`=0.
  - `alu_reg_en`=0, `alu_add`=0, `alu_load`=0, `alu_imm`=0.
  - `res_valid`=0, `res_data`=0, `op_count`=0.
- Reset mid-sequence aborts immediately: all enables drop in the same cycle and any pending result is discarded.
- Acceptance occurs on a rising edge where `instr_valid` && `instr_ready`.
- Latency from acceptance edge to `res_valid`=1 is 4 cycles (ISSUE, MULT, CAPT, then HOLD visible).
- Throughput is one op per 5 cycles with `res_ready` held high.
- `instr_ready` is a registered state decode (IDLE only), with no combinational path from `instr_valid`.
- `instr_ready`=0 from the cycle after acceptance until the cycle after the result handshake.
- Back-to-back: a result handshake returns to IDLE. The next instruction can be accepted on the following edge, with no result/instr overlap.
- `res_ready` asserted before `res_valid` has no effect.
- NOP accepted in IDLE keeps `instr_ready`=1. Consecutive NOPs are accepted every cycle.

## Configuration
- **`ALU_SEQ_PERF_EN` defined**
  - The `op_count` port exists.
  - `op_count` increments by 1 on every result handshake (`res_valid` && `res_ready`).
  - NOPs are not counted.
  - It wraps from 2^CNT_WIDTH−1 to 0 and resets to 0.
- **`ALU_SEQ_PERF_EN` undefined**
  - The `op_count` port and the counter logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `instr_valid`=1 -> outputs at reset values, no acceptance. After release, `instr_ready`=1.
- ADDI, imm=0x05, ALU model returning 0x2A: `alu_reg_en` sequence 5'b10011, 5'b01100, 0; `alu_add`=1; `res_valid` 4 cycles after acceptance with `res_data`=0x2A.
- MOV then LDSW back-to-back with `res_ready`=1: `alu_load`=1 then 0. Second acceptance exactly 5 cycles after the first; both results correct.
- Backpressure: `res_ready`=0 for 10 cycles during HOLD with `alu_result` toggling -> `res_data` frozen, `instr_ready`=0, no enables asserted.
- Async reset in MULT -> `alu_reg_en`=0 in the same cycle, no `res_valid`, next instruction accepted normally.
- With `ALU_SEQ_PERF_EN`, CNT_WIDTH=2: 5 ADDIs and 3 NOPs -> `op_count` = 1 (wrapped), NOPs consumed in 1 cycle each.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Issue-side sequencer for the 8-bit ALU: accepts one instruction, steps the ALU through ISSUE/MULT/CAPT, holds the result.
// Optional op counter enabled by defining ALU_SEQ_PERF_EN.
module alu_seq_ctrl #(
    parameter int BUS_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [1:0]           instr_op,
    input  logic [BUS_WIDTH-1:0] instr_imm,
    output logic [4:0]           alu_reg_en,
    output logic                 alu_add,
    output logic                 alu_load,
    output logic [BUS_WIDTH-1:0] alu_imm,
    input  logic [BUS_WIDTH-1:0] alu_result,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [BUS_WIDTH-1:0] res_data
`ifdef ALU_SEQ_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] op_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_MULT,
        S_CAPT,
        S_HOLD
    } state_t;

    typedef enum logic [1:0] {
        OP_LDSW = 2'b00,
        OP_MOV  = 2'b01,
        OP_ADDI = 2'b10,
        OP_NOP  = 2'b11
    } op_t;

    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $error("CNT_WIDTH must be at least 1");
    end

    state_t               r_state;
    state_t               w_next_state;
    op_t                  r_op;
    logic [BUS_WIDTH-1:0] r_imm;
    logic [BUS_WIDTH-1:0] r_res_data;
    logic                 w_accept;
    logic                 w_res_hs;

    // Gated by rst_n so the port reads 0 while reset is held, even though state already sits in IDLE.
    assign instr_ready = (r_state == S_IDLE) && rst_n;
    assign w_accept    = instr_valid && (r_state == S_IDLE);
    assign w_res_hs    = (r_state == S_HOLD) && res_ready;
    assign res_valid   = (r_state == S_HOLD);
    assign res_data    = r_res_data;
    assign alu_imm     = r_imm;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_op       <= OP_NOP;
            r_imm      <= '0;
            r_res_data <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_op  <= op_t'(instr_op);
                r_imm <= instr_imm;
            end
            if (r_state == S_CAPT) begin
                r_res_data <= alu_result;
            end
        end
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        alu_reg_en   = 5'b0_0000;
        alu_add      = 1'b0;
        alu_load     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (instr_valid && (op_t'(instr_op) != OP_NOP)) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                alu_reg_en   = 5'b1_0011;
                alu_add      = (r_op == OP_ADDI);
                alu_load     = (r_op == OP_MOV);
                w_next_state = S_MULT;
            end
            S_MULT: begin
                alu_reg_en   = 5'b0_1100;
                alu_add      = (r_op == OP_ADDI);
                alu_load     = (r_op == OP_MOV);
                w_next_state = S_CAPT;
            end
            S_CAPT: begin
                w_next_state = S_HOLD;
            end
            S_HOLD: begin
                if (res_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

`ifdef ALU_SEQ_PERF_EN
    logic [CNT_WIDTH-1:0] r_op_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (w_res_hs) begin
            r_op_count <= r_op_count + 1'b1;
        end
    end

    assign op_count = r_op_count;
`else
    logic w_unused_hs;
    assign w_unused_hs = w_res_hs;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl; inputs change and outputs are sampled on the falling clock edge.
// Op-counter scenario runs only when ALU_SEQ_PERF_EN is defined.
module tb_alu_seq_ctrl;

`ifdef ALU_SEQ_PERF_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [1:0] instr_op;
    logic [7:0] instr_imm;
    logic [4:0] alu_reg_en;
    logic       alu_add;
    logic       alu_load;
    logic [7:0] alu_imm;
    logic [7:0] alu_result;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
`ifdef ALU_SEQ_PERF_EN
    logic [CNT_W-1:0] op_count;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cyc[$];

    alu_seq_ctrl #(.BUS_WIDTH(8), .CNT_WIDTH(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_imm   (instr_imm),
        .alu_reg_en  (alu_reg_en),
        .alu_add     (alu_add),
        .alu_load    (alu_load),
        .alu_imm     (alu_imm),
        .alu_result  (alu_result),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data)
`ifdef ALU_SEQ_PERF_EN
        ,
        .op_count    (op_count)
`endif
    );

    always #5 clk = ~clk;

    // Records the cycle index of every acceptance edge.
    always @(posedge clk) begin
        if (rst_n && instr_valid && instr_ready) acc_cyc.push_back(cyc);
        cyc <= cyc + 1;
    end

    task automatic test_reset();
        rst_n = 1'b0; instr_valid = 1'b1; instr_op = 2'b10; instr_imm = 8'hA5;
        alu_result = 8'h3C; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (instr_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", instr_ready); end
        checks++; if (alu_reg_en !== 5'b00000) begin failures++; $display("FAIL reset_reg_en got=%b exp=00000", alu_reg_en); end
        checks++; if ({alu_add, alu_load} !== 2'b00) begin failures++; $display("FAIL reset_add_load got=%b exp=00", {alu_add, alu_load}); end
        checks++; if (alu_imm !== 8'h00) begin failures++; $display("FAIL reset_imm got=%h exp=00", alu_imm); end
        checks++; if (res_valid !== 1'b0 || res_data !== 8'h00) begin failures++; $display("FAIL reset_res got=%b/%h exp=0/00", res_valid, res_data); end
        checks++; if (acc_cyc.size() !== 0) begin failures++; $display("FAIL reset_no_accept got=%0d exp=0", acc_cyc.size()); end
        instr_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", instr_ready); end
    endtask

    task automatic test_addi();
        @(negedge clk);
        instr_valid = 1'b1; instr_op = 2'b10; instr_imm = 8'h05; alu_result = 8'h2A; res_ready = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0;
        checks++; if (alu_reg_en !== 5'b10011) begin failures++; $display("FAIL addi_issue_en got=%b exp=10011", alu_reg_en); end
        checks++; if ({alu_add, alu_load} !== 2'b10) begin failures++; $display("FAIL addi_issue_sel got=%b exp=10", {alu_add, alu_load}); end
        checks++; if (alu_imm !== 8'h05) begin failures++; $display("FAIL addi_imm got=%h exp=05", alu_imm); end
        checks++; if (instr_ready !== 1'b0) begin failures++; $display("FAIL addi_busy_ready got=%b exp=0", instr_ready); end
        @(negedge clk);
        checks++; if (alu_reg_en !== 5'b01100) begin failures++; $display("FAIL addi_mult_en got=%b exp=01100", alu_reg_en); end
        checks++; if ({alu_add, alu_load} !== 2'b10) begin failures++; $display("FAIL addi_mult_sel got=%b exp=10", {alu_add, alu_load}); end
        @(negedge clk);
        checks++; if (alu_reg_en !== 5'b00000 || res_valid !== 1'b0) begin failures++; $display("FAIL addi_capt got=%b/%b exp=00000/0", alu_reg_en, res_valid); end
        @(negedge clk);
        checks++; if (res_valid !== 1'b1 || res_data !== 8'h2A) begin failures++; $display("FAIL addi_result got=%b/%h exp=1/2a", res_valid, res_data); end
        checks++; if ({alu_add, alu_load} !== 2'b00) begin failures++; $display("FAIL addi_hold_sel got=%b exp=00", {alu_add, alu_load}); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++; if (res_valid !== 1'b0 || instr_ready !== 1'b1) begin failures++; $display("FAIL addi_done got=%b/%b exp=0/1", res_valid, instr_ready); end
    endtask

    task automatic test_back_to_back();
        res_ready = 1'b1;
        instr_valid = 1'b1; instr_op = 2'b01; instr_imm = 8'h33; alu_result = 8'h11;
        @(negedge clk);
        instr_valid = 1'b0;
        checks++; if ({alu_add, alu_load} !== 2'b01) begin failures++; $display("FAIL b2b_mov_sel got=%b exp=01", {alu_add, alu_load}); end
        repeat (3) @(negedge clk);
        checks++; if (res_valid !== 1'b1 || res_data !== 8'h11) begin failures++; $display("FAIL b2b_mov_res got=%b/%h exp=1/11", res_valid, res_data); end
        @(negedge clk);
        checks++; if (instr_ready !== 1'b1 || res_valid !== 1'b0) begin failures++; $display("FAIL b2b_gap got=%b/%b exp=1/0", instr_ready, res_valid); end
        instr_valid = 1'b1; instr_op = 2'b00; instr_imm = 8'h77; alu_result = 8'hF0;
        @(negedge clk);
        instr_valid = 1'b0;
        checks++; if ({alu_add, alu_load} !== 2'b00 || alu_reg_en !== 5'b10011) begin failures++; $display("FAIL b2b_ldsw_issue got=%b/%b exp=00/10011", {alu_add, alu_load}, alu_reg_en); end
        checks++; if (alu_imm !== 8'h77) begin failures++; $display("FAIL b2b_imm got=%h exp=77", alu_imm); end
        checks++;
        if (acc_cyc.size() < 2) begin failures++; $display("FAIL b2b_accepts got=%0d exp>=2", acc_cyc.size()); end
        else if (acc_cyc[$] - acc_cyc[$-1] !== 5) begin failures++; $display("FAIL b2b_spacing got=%0d exp=5", acc_cyc[$] - acc_cyc[$-1]); end
        repeat (3) @(negedge clk);
        checks++; if (res_valid !== 1'b1 || res_data !== 8'hF0) begin failures++; $display("FAIL b2b_ldsw_res got=%b/%h exp=1/f0", res_valid, res_data); end
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        instr_valid = 1'b1; instr_op = 2'b10; instr_imm = 8'h01; alu_result = 8'h5C;
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            alu_result = ~alu_result;
            @(negedge clk);
            checks++;
            if (res_data !== 8'h5C || res_valid !== 1'b1 || instr_ready !== 1'b0 || alu_reg_en !== 5'b00000) begin
                failures++;
                $display("FAIL bp_hold[%0d] got data=%h valid=%b ready=%b en=%b exp=5c/1/0/00000", i, res_data, res_valid, instr_ready, alu_reg_en);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++; if (res_valid !== 1'b0 || instr_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%b/%b exp=0/1", res_valid, instr_ready); end
    endtask

    task automatic test_reset_mid();
        instr_valid = 1'b1; instr_op = 2'b10; instr_imm = 8'h09; alu_result = 8'h44;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        checks++; if (alu_reg_en !== 5'b01100) begin failures++; $display("FAIL rst_mid_mult got=%b exp=01100", alu_reg_en); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (alu_reg_en !== 5'b00000 || alu_add !== 1'b0) begin failures++; $display("FAIL rst_mid_drop got=%b/%b exp=00000/0", alu_reg_en, alu_add); end
        checks++; if (res_valid !== 1'b0 || instr_ready !== 1'b0 || alu_imm !== 8'h00) begin failures++; $display("FAIL rst_mid_outs got=%b/%b/%h exp=0/0/00", res_valid, instr_ready, alu_imm); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (res_valid !== 1'b0 || instr_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_idle got=%b/%b exp=0/1", res_valid, instr_ready); end
        instr_valid = 1'b1; instr_op = 2'b00; instr_imm = 8'h02; alu_result = 8'h99;
        @(negedge clk);
        instr_valid = 1'b0;
        checks++; if (alu_reg_en !== 5'b10011) begin failures++; $display("FAIL rst_mid_reissue got=%b exp=10011", alu_reg_en); end
        repeat (3) @(negedge clk);
        checks++; if (res_valid !== 1'b1 || res_data !== 8'h99) begin failures++; $display("FAIL rst_mid_res got=%b/%h exp=1/99", res_valid, res_data); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_nop();
        int n0;
        n0 = acc_cyc.size();
        instr_valid = 1'b1; instr_op = 2'b11; instr_imm = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (instr_ready !== 1'b1 || alu_reg_en !== 5'b00000 || res_valid !== 1'b0) begin
                failures++;
                $display("FAIL nop[%0d] got ready=%b en=%b valid=%b exp=1/00000/0", i, instr_ready, alu_reg_en, res_valid);
            end
        end
        instr_valid = 1'b0;
        checks++; if (acc_cyc.size() - n0 !== 3) begin failures++; $display("FAIL nop_accepts got=%0d exp=3", acc_cyc.size() - n0); end
    endtask

`ifdef ALU_SEQ_PERF_EN
    task automatic test_perf();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (op_count !== 2'd0) begin failures++; $display("FAIL perf_reset got=%0d exp=0", op_count); end
        @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            instr_valid = 1'b1; instr_op = 2'b10; instr_imm = 8'(i); alu_result = 8'(i + 1);
            @(negedge clk);
            instr_valid = 1'b0;
            repeat (4) @(negedge clk);
            if (i < 3) begin
                instr_valid = 1'b1; instr_op = 2'b11;
                @(negedge clk);
                instr_valid = 1'b0;
                checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL perf_nop[%0d] got=%b exp=1", i, instr_ready); end
            end
        end
        res_ready = 1'b0;
        checks++; if (op_count !== 2'd1) begin failures++; $display("FAIL perf_count got=%0d exp=1", op_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_nop();
`ifdef ALU_SEQ_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
